pipeline_hazard_ctrl: RTL and testbench

- Control-side counterpart to the IF/ID, ID/EX and EX/MEM pipeline registers of the 2-slot VLIW core (ALU slot plus MEM slot).
- Produces the write-enable (regWrite) and bubble/flush controls those registers consume: load-use stalls, branch/jump flushes, memory-wait freezes and the undefined-instruction halt.
- Sits beside the decode stage; reads register indices from ID, and control bits from EX and MEM.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 28 ++
 rtl/pipeline_hazard_ctrl_cmp4.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Purpose: shared encodings for the hazard controller (FSM states, halt causes, source-flag positions).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

  // Controller states; HALT is absorbing until reset.
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_t;

  // halt_cause codes
  localparam logic [1:0] CAUSE_NONE        = 2'b00;
  localparam logic [1:0] CAUSE_ALU_UNDEF   = 2'b01;
  localparam logic [1:0] CAUSE_MEM_UNDEF   = 2'b10;
  localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'b11;

  // Bit positions inside id_src_valid
  localparam int SRC_ALU_RN = 0;
  localparam int SRC_ALU_RM = 1;
  localparam int SRC_MEM_RN = 2;
  localparam int SRC_MEM_RD = 3;

  // Memory-wait counter width; wide enough for MEM_TIMEOUT up to 65535.
  localparam int WAIT_W = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_cmp4.sv
// Purpose: load-use detector; compares the four ID source indices against the EX load destination.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result feeds the stall decision in the controller.
// Ports: alu_rn/alu_rm/mem_rn/mem_rd - ID source indices; src_valid - per-source use mask;
//        load - EX MEM-slot holds a load; load_rd - its destination; hit - load-use hazard.
module hazard_cmp4
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [2:0] alu_rn,
  input  logic [2:0] alu_rm,
  input  logic [2:0] mem_rn,
  input  logic [2:0] mem_rd,
  input  logic [3:0] src_valid,
  input  logic       load,
  input  logic [2:0] load_rd,
  output logic       hit
);

  logic [3:0] match;

  // r0 is an ordinary register in this core, so index 0 is compared like any other.
  always_comb begin
    match             = 4'b0000;
    match[SRC_ALU_RN] = src_valid[SRC_ALU_RN] && (alu_rn == load_rd);
    match[SRC_ALU_RM] = src_valid[SRC_ALU_RM] && (alu_rm == load_rd);
    match[SRC_MEM_RN] = src_valid[SRC_MEM_RN] && (mem_rn == load_rd);
    match[SRC_MEM_RD] = src_valid[SRC_MEM_RD] && (mem_rd == load_rd);
  end

  assign hit = load && (|match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: generates pipeline-register write enables, flush and bubble controls for the 2-slot VLIW core.
// Latency: hazard responses are combinational from registered state plus inputs; state moves on the next clk.
// Backpressure: mem_req without mem_ready freezes every stage until ready; a stuck memory halts after MEM_TIMEOUT.
// Ports:
//   clk, reset (async, active-low)
//   id_*            register indices and use flags of the bundle in ID
//   ex_*            load, control-transfer and undefined-instruction flags of the bundle in EX
//   mem_req/ready   data-memory handshake of the MEM stage
//   pcWrite, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble  pipeline controls
//   halted, halt_cause, stall_count  status
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       id_alu_rn,
  input  logic [2:0]       id_alu_rm,
  input  logic [2:0]       id_mem_rn,
  input  logic [2:0]       id_mem_rd,
  input  logic [3:0]       id_src_valid,
  input  logic             ex_memRead,
  input  logic [2:0]       ex_mem_rd,
  input  logic             ex_branchTaken,
  input  logic             ex_isJump,
  input  logic             ex_alu_undef,
  input  logic             ex_mem_undef,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pcWrite,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] stall_count
);

  // Last wait-counter value before timing out; the counter starts at 0 on entry,
  // so reaching this value with no ready means MEM_TIMEOUT wait cycles have elapsed.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              halted_q;
  logic [1:0]        cause_q;
  logic [1:0]        entry_cause;

  logic load_use;
  logic undef;
  logic mem_stall;
  logic xfer;

  hazard_cmp4 u_cmp (
    .alu_rn    (id_alu_rn),
    .alu_rm    (id_alu_rm),
    .mem_rn    (id_mem_rn),
    .mem_rd    (id_mem_rd),
    .src_valid (id_src_valid),
    .load      (ex_memRead),
    .load_rd   (ex_mem_rd),
    .hit       (load_use)
  );

  assign undef     = ex_alu_undef || ex_mem_undef;
  assign mem_stall = mem_req && !mem_ready;
  assign xfer      = ex_branchTaken || ex_isJump;

  // ---------------------------------------------------------------
  // State register plus the registered status it owns
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      halted_q    <= 1'b0;
      cause_q     <= CAUSE_NONE;
    end else begin
      state_q <= state_d;

      // Counter only runs while staying in MEM_WAIT; any other state holds it at 0,
      // which gives a clean count on every fresh entry.
      if (state_q == ST_MEM_WAIT && state_d == ST_MEM_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end

      if (state_q != ST_HALT && state_d == ST_HALT) begin
        halted_q <= 1'b1;
        cause_q  <= entry_cause;
      end

      // Saturating: stops at all-ones instead of wrapping.
      if (!pcWrite && state_q != ST_HALT && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    entry_cause = CAUSE_NONE;
    case (state_q)
      ST_RUN: begin
        if (undef) begin
          state_d     = ST_HALT;
          // ALU slot wins when both slots are undefined.
          entry_cause = ex_alu_undef ? CAUSE_ALU_UNDEF : CAUSE_MEM_UNDEF;
        end else if (mem_stall) begin
          state_d = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d     = ST_HALT;
          entry_cause = CAUSE_MEM_TIMEOUT;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------
  always_comb begin
    // Safe defaults: nothing advances and ID/EX receives a bubble.
    pcWrite     = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    exmem_write = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;

    if (reset) begin
      case (state_q)
        ST_RUN: begin
          if (undef) begin
            // Keep defaults: freeze and bubble while the halt takes effect.
          end else if (mem_stall) begin
            idex_bubble = 1'b0;
          end else if (xfer) begin
            // Flush wins over load-use: the dependent instruction is being squashed anyway.
            pcWrite     = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            ifid_flush  = 1'b1;
          end else if (load_use) begin
            // Hold IF/ID and PC, inject one bubble; the load moves on to MEM this edge.
            idex_write  = 1'b1;
            exmem_write = 1'b1;
          end else begin
            pcWrite     = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            idex_bubble = 1'b0;
          end
        end
        ST_MEM_WAIT: begin
          idex_bubble = 1'b0;
        end
        default: begin
          // HALT and illegal encodings keep the frozen defaults.
        end
      endcase
    end
  end

  assign halted      = halted_q;
  assign halt_cause  = cause_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int TO = 8;
  localparam int CW = 4;

  localparam logic [5:0] C_RESET  = 6'b000001; // {pc,ifid,idex,exmem,flush,bubble}
  localparam logic [5:0] C_NORM   = 6'b111100;
  localparam logic [5:0] C_LDUSE  = 6'b001101;
  localparam logic [5:0] C_FLUSH  = 6'b111111;
  localparam logic [5:0] C_FREEZE = 6'b000000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    id_alu_rn, id_alu_rm, id_mem_rn, id_mem_rd;
  logic [3:0]    id_src_valid;
  logic          ex_memRead;
  logic [2:0]    ex_mem_rd;
  logic          ex_branchTaken, ex_isJump, ex_alu_undef, ex_mem_undef;
  logic          mem_req, mem_ready;
  logic          pcWrite, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble;
  logic          halted;
  logic [1:0]    halt_cause;
  logic [CW-1:0] stall_count;
  logic [5:0]    ctl;

  int errors = 0;
  int checks = 0;

  assign ctl = {pcWrite, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_alu_rn(id_alu_rn), .id_alu_rm(id_alu_rm), .id_mem_rn(id_mem_rn), .id_mem_rd(id_mem_rd),
    .id_src_valid(id_src_valid), .ex_memRead(ex_memRead), .ex_mem_rd(ex_mem_rd),
    .ex_branchTaken(ex_branchTaken), .ex_isJump(ex_isJump),
    .ex_alu_undef(ex_alu_undef), .ex_mem_undef(ex_mem_undef),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .ifid_write(ifid_write), .idex_write(idex_write), .exmem_write(exmem_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .halted(halted), .halt_cause(halt_cause), .stall_count(stall_count)
  );

  task idle();
    id_alu_rn = 3'd0; id_alu_rm = 3'd0; id_mem_rn = 3'd0; id_mem_rd = 3'd0;
    id_src_valid = 4'b0000; ex_memRead = 1'b0; ex_mem_rd = 3'd0;
    ex_branchTaken = 1'b0; ex_isJump = 1'b0; ex_alu_undef = 1'b0; ex_mem_undef = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task load_use_alu_rm5();
    idle();
    ex_memRead = 1'b1; ex_mem_rd = 3'd5; id_alu_rm = 3'd5; id_src_valid = 4'b0010;
  endtask

  task test_reset();
    idle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (ctl !== C_RESET) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RESET); end
    end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_count); end
    checks++; if ({halted, halt_cause} !== 3'b000) begin errors++; $display("FAIL reset_halt: got %b want 000", {halted, halt_cause}); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL post_reset_ctl: got %b want %b", ctl, C_NORM); end
    @(negedge clk); #1;
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL post_reset_stall: got %0d want 0", stall_count); end
  endtask

  task test_load_use();
    @(negedge clk); load_use_alu_rm5(); #1;
    checks++; if (ctl !== C_LDUSE) begin errors++; $display("FAIL lu_ctl: got %b want %b", ctl, C_LDUSE); end
    @(negedge clk); idle(); #1;
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL lu_after_ctl: got %b want %b", ctl, C_NORM); end
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_stall: got %0d want 1", stall_count); end
    // Same indices, source not used: no hazard.
    @(negedge clk); load_use_alu_rm5(); id_src_valid = 4'b0000; #1;
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL lu_novalid_ctl: got %b want %b", ctl, C_NORM); end
    // Used source but different register: no hazard.
    @(negedge clk); idle(); ex_memRead = 1'b1; ex_mem_rd = 3'd3; id_alu_rn = 3'd2; id_src_valid = 4'b0001; #1;
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL lu_diffreg_ctl: got %b want %b", ctl, C_NORM); end
    // r0 as store data participates.
    @(negedge clk); idle(); ex_memRead = 1'b1; ex_mem_rd = 3'd0; id_mem_rd = 3'd0; id_src_valid = 4'b1000; #1;
    checks++; if (ctl !== C_LDUSE) begin errors++; $display("FAIL lu_r0_ctl: got %b want %b", ctl, C_LDUSE); end
    @(negedge clk); idle(); #1;
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL lu_r0_stall: got %0d want 2", stall_count); end
  endtask

  task test_flush();
    @(negedge clk); load_use_alu_rm5(); ex_branchTaken = 1'b1; #1;
    checks++; if (ctl !== C_FLUSH) begin errors++; $display("FAIL flush_lu_ctl: got %b want %b", ctl, C_FLUSH); end
    @(negedge clk); idle(); ex_isJump = 1'b1; #1;
    checks++; if (ctl !== C_FLUSH) begin errors++; $display("FAIL jump_ctl: got %b want %b", ctl, C_FLUSH); end
    @(negedge clk); idle(); #1;
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL flush_stall: got %0d want 2", stall_count); end
  endtask

  task test_mem_wait();
    @(negedge clk); idle(); mem_req = 1'b1; #1;
    checks++; if (ctl[5:2] !== 4'b0000) begin errors++; $display("FAIL mw_enter_en: got %b want 0000", ctl[5:2]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_req = 1'b1; mem_ready = 1'b0; #1;
      checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL mw_wait_ctl: got %b want %b", ctl, C_FREEZE); end
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL mw_ready_ctl: got %b want %b", ctl, C_FREEZE); end
    // Exit cycle runs normal RUN rules immediately.
    @(negedge clk); load_use_alu_rm5(); #1;
    checks++; if (ctl !== C_LDUSE) begin errors++; $display("FAIL mw_exit_ctl: got %b want %b", ctl, C_LDUSE); end
    checks++; if (stall_count !== 4'd7) begin errors++; $display("FAIL mw_stall: got %0d want 7", stall_count); end
    @(negedge clk); idle(); #1;
    checks++; if (stall_count !== 4'd8) begin errors++; $display("FAIL mw_lu_stall: got %0d want 8", stall_count); end
  endtask

  task test_saturate();
    // RUN cycle + 7 wait cycles (one short of timeout) + ready cycle = 9 stalls; 8+9 saturates at 15.
    @(negedge clk); idle(); mem_req = 1'b1; #1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); mem_req = 1'b1; mem_ready = 1'b0; #1;
      checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL sat_wait_ctl: got %b want %b", ctl, C_FREEZE); end
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    @(negedge clk); idle(); #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL sat_no_halt: got %b want 0", halted); end
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL sat_ctl: got %b want %b", ctl, C_NORM); end
    checks++; if (stall_count !== 4'hF) begin errors++; $display("FAIL sat_stall: got %0d want 15", stall_count); end
    @(negedge clk); load_use_alu_rm5(); #1;
    @(negedge clk); idle(); #1;
    checks++; if (stall_count !== 4'hF) begin errors++; $display("FAIL sat_nowrap: got %0d want 15", stall_count); end
  endtask

  task test_async_reset();
    @(negedge clk); idle(); mem_req = 1'b1; #1;
    @(negedge clk); #1;
    checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL ar_wait_ctl: got %b want %b", ctl, C_FREEZE); end
    reset = 1'b0; #1;
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL ar_stall: got %0d want 0", stall_count); end
    checks++; if (ctl !== C_RESET) begin errors++; $display("FAIL ar_ctl: got %b want %b", ctl, C_RESET); end
    @(negedge clk); reset = 1'b1; idle(); #1;
    checks++; if (ctl !== C_NORM) begin errors++; $display("FAIL ar_run_ctl: got %b want %b", ctl, C_NORM); end
  endtask

  task test_timeout();
    @(negedge clk); idle(); mem_req = 1'b1; #1;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk); mem_req = 1'b1; mem_ready = 1'b0; #1;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL to_early_halt: got %b want 0 at wait %0d", halted, i); end
    end
    @(negedge clk); #1;
    checks++; if ({halted, halt_cause} !== 3'b111) begin errors++; $display("FAIL to_halt: got %b want 111", {halted, halt_cause}); end
    checks++; if (ctl !== C_RESET) begin errors++; $display("FAIL to_ctl: got %b want %b", ctl, C_RESET); end
    checks++; if (stall_count !== 4'd9) begin errors++; $display("FAIL to_stall: got %0d want 9", stall_count); end
    @(negedge clk); mem_ready = 1'b1; #1;
    @(negedge clk); idle(); #1;
    checks++; if ({halted, halt_cause, ctl} !== {3'b111, C_RESET}) begin errors++; $display("FAIL to_absorb: got %b want %b", {halted, halt_cause, ctl}, {3'b111, C_RESET}); end
    checks++; if (stall_count !== 4'd9) begin errors++; $display("FAIL to_stall_hold: got %0d want 9", stall_count); end
    reset = 1'b0; #1;
    checks++; if ({halted, halt_cause, stall_count} !== 7'd0) begin errors++; $display("FAIL to_reset_clear: got %b want 0", {halted, halt_cause, stall_count}); end
  endtask

  task test_undef();
    @(negedge clk); reset = 1'b1; idle(); #1;
    @(negedge clk); ex_alu_undef = 1'b1; ex_mem_undef = 1'b1; mem_req = 1'b1; #1;
    checks++; if (ctl !== C_RESET) begin errors++; $display("FAIL undef_same_ctl: got %b want %b", ctl, C_RESET); end
    @(negedge clk); idle(); #1;
    checks++; if ({halted, halt_cause} !== 3'b101) begin errors++; $display("FAIL undef_both: got %b want 101", {halted, halt_cause}); end
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL undef_stall: got %0d want 1", stall_count); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (ctl !== C_RESET) begin errors++; $display("FAIL undef_hold_ctl: got %b want %b", ctl, C_RESET); end
    end
    @(negedge clk); reset = 1'b0; #1;
    @(negedge clk); reset = 1'b1; idle(); ex_mem_undef = 1'b1; ex_branchTaken = 1'b1; #1;
    checks++; if (ctl !== C_RESET) begin errors++; $display("FAIL memundef_ctl: got %b want %b", ctl, C_RESET); end
    @(negedge clk); idle(); #1;
    checks++; if ({halted, halt_cause} !== 3'b110) begin errors++; $display("FAIL memundef_cause: got %b want 110", {halted, halt_cause}); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_flush();
    test_mem_wait();
    test_saturate();
    test_async_reset();
    test_timeout();
    test_undef();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
